// File: rtl/request_serializer_pkg.sv
// Shared line-symbol encodings, FSM state type and small helpers for the request serializer.
package request_serializer_pkg;

  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_ZERO = 2'b10;
  localparam logic [1:0] SYM_IDLE = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

  function automatic logic [1:0] bit_to_sym(input logic b);
    return b ? SYM_ONE : SYM_ZERO;
  endfunction

endpackage

// File: rtl/request_serializer_if.sv
// Request handshake plus serial line outputs of the request serializer.
interface request_serializer_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] req_data;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        user_output;
  logic              busy;
  logic              frame_done;

  modport master (
    output req_data, req_valid,
    input  req_ready, user_output, busy, frame_done
  );

  modport slave (
    input  req_data, req_valid,
    output req_ready, user_output, busy, frame_done
  );
endinterface

// File: rtl/request_serializer_fifo.sv
// Small synchronous FIFO holding pending requests; occupancy is kept in a register.
module request_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/request_serializer.sv
// Queues requests and serialises each one as header, payload, optional parity and stop bit,
// each bit held for BIT_CYCLES clocks, with GAP_CYCLES idle clocks between frames.
module request_serializer
  import request_serializer_pkg::*;
#(
  parameter int               DATA_W     = 12,
  parameter int               HDR_W      = 4,
  parameter logic [HDR_W-1:0] HDR        = 4'b1101,
  parameter int               PARITY_EN  = 0,
  parameter int               BIT_CYCLES = 25,
  parameter int               GAP_CYCLES = 25,
  parameter int               FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  request_serializer_if.slave  bus
);
  localparam int FRAME_W   = HDR_W + DATA_W + PARITY_EN + 1;
  localparam int BIT_CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int CYC_CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GAP_CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_W - 1);
  localparam logic [CYC_CNT_W-1:0] CYC_LAST = CYC_CNT_W'(BIT_CYCLES - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [CYC_CNT_W-1:0] cyc_q, cyc_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic [1:0]           sym_q, sym_d;
  logic                 done_q, done_d;

  logic [DATA_W-1:0]    fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [FRAME_W-1:0]   frame_load;

  assign fifo_push = bus.req_valid & ~fifo_full;
  assign fifo_pop  = (state_q == LOAD);

  request_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (bus.req_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.req_ready   = ~fifo_full;
  assign bus.busy        = (state_q != IDLE) | ~fifo_empty;
  assign bus.user_output = sym_q;
  assign bus.frame_done  = done_q;

  // Assemble the outgoing frame from the queue head, MSB transmitted first; LSB is the stop bit.
  always_comb begin
    frame_load = '0;
    frame_load[FRAME_W-1 -: HDR_W]          = HDR;
    frame_load[FRAME_W-1-HDR_W -: DATA_W]   = fifo_rd_data;
    if (PARITY_EN != 0) begin
      frame_load[1] = ^fifo_rd_data;
    end
  end

  // Sequencer next-state: symbols are computed one clock ahead so the line output is a flop.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    gap_d   = gap_q;
    sym_d   = sym_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sym_d = SYM_IDLE;
        if (!fifo_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        frame_d = frame_load;
        bit_d   = '0;
        cyc_d   = '0;
        sym_d   = bit_to_sym(frame_load[FRAME_W-1]);
        state_d = SEND;
      end
      SEND: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            sym_d  = SYM_IDLE;
            done_d = 1'b1;
            bit_d  = '0;
            if (GAP_CYCLES > 0) begin
              gap_d   = '0;
              state_d = GAP;
            end else if (!fifo_empty) begin
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d   = bit_q + BIT_CNT_W'(1);
            frame_d = frame_q << 1;
            sym_d   = bit_to_sym(frame_q[FRAME_W-2]);
          end
        end else begin
          cyc_d = cyc_q + CYC_CNT_W'(1);
        end
      end
      GAP: begin
        sym_d = SYM_IDLE;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = fifo_empty ? IDLE : LOAD;
        end else begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end
      end
      default: begin
        sym_d   = SYM_IDLE;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset drops any partial frame and idles the line at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      gap_q   <= '0;
      sym_q   <= SYM_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      gap_q   <= gap_d;
      sym_q   <= sym_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_request_serializer.sv
// Bench for request_serializer: DUT A uses defaults, DUT B uses parity, 1-clock bits and no gap.
module tb_request_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  request_serializer_if #(.DATA_W(12)) ifa ();
  request_serializer_if #(.DATA_W(12)) ifb ();

  request_serializer #(.DATA_W(12)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  request_serializer #(
    .DATA_W     (12),
    .PARITY_EN  (1),
    .BIT_CYCLES (1),
    .GAP_CYCLES (0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: payloads pushed on acceptance, popped when a frame starts on the line
  logic [11:0] exp0[$];
  logic [11:0] exp1[$];

  int          m_state[2];
  int          m_pos[2];
  int          m_gap[2];
  logic [31:0] m_bits[2];
  int          start_log[2][32];
  int          fd_log[2][32];
  int          start_n[2];
  int          fd_n[2];
  int          last_acc[2];

  function automatic int bc_of(input int i);
    return (i == 0) ? 25 : 1;
  endfunction
  function automatic int gap_of(input int i);
    return (i == 0) ? 25 : 0;
  endfunction
  function automatic int fw_of(input int i);
    return (i == 0) ? 17 : 18;
  endfunction
  function automatic logic [1:0] sym_of(input logic b);
    return b ? 2'b01 : 2'b10;
  endfunction
  function automatic logic [31:0] frame_bits(input int i, input logic [11:0] d);
    if (i == 0) return {15'b0, 4'b1101, d, 1'b0};
    else        return {14'b0, 4'b1101, d, ^d, 1'b0};
  endfunction
  function automatic logic rdy(input int i);
    return (i == 0) ? ifa.req_ready : ifb.req_ready;
  endfunction
  function automatic logic bsy(input int i);
    return (i == 0) ? ifa.busy : ifb.busy;
  endfunction

  task automatic mon_step(input int i, input logic [1:0] s, input logic fd);
    int fw;
    int bc;
    int idx;
    logic [1:0] es;
    logic [11:0] d;
    fw = fw_of(i);
    bc = bc_of(i);
    checks++;
    if (s === 2'b11) begin
      errors++;
      $display("FAIL illegal_symbol dut%0d cyc%0d: got %b, required not 11", i, cyc, s);
    end
    if (fd === 1'b1) begin
      if (fd_n[i] < 32) fd_log[i][fd_n[i]] = cyc;
      fd_n[i]++;
    end
    if (m_state[i] == 0 && s !== 2'b00) begin
      checks++;
      if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
        errors++;
        $display("FAIL unexpected_frame dut%0d cyc%0d: got frame start, required none pending", i, cyc);
        d = '0;
      end else begin
        d = (i == 0) ? exp0.pop_front() : exp1.pop_front();
      end
      m_bits[i] = frame_bits(i, d);
      if (start_n[i] < 32) start_log[i][start_n[i]] = cyc;
      start_n[i]++;
      m_pos[i]   = 0;
      m_state[i] = 1;
    end
    if (m_state[i] == 1) begin
      if (m_pos[i] < fw * bc) begin
        idx = m_pos[i] / bc;
        es  = sym_of(m_bits[i][fw-1-idx]);
        checks++;
        if (s !== es) begin
          errors++;
          $display("FAIL symbol dut%0d bit%0d cyc%0d: got %b, expected %b", i, idx, cyc, s, es);
        end
        m_pos[i]++;
      end else begin
        checks++;
        if (s !== 2'b00 || fd !== 1'b1) begin
          errors++;
          $display("FAIL frame_end dut%0d cyc%0d: got sym %b done %b, expected 00 and 1", i, cyc, s, fd);
        end
        if (gap_of(i) > 1) begin
          m_gap[i]   = 1;
          m_state[i] = 2;
        end else begin
          m_state[i] = 0;
        end
      end
    end else if (m_state[i] == 2) begin
      checks++;
      if (s !== 2'b00) begin
        errors++;
        $display("FAIL gap_symbol dut%0d cyc%0d: got %b, expected 00", i, cyc, s);
      end
      m_gap[i]++;
      if (m_gap[i] >= gap_of(i)) m_state[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_state[i] = 0;
        m_pos[i]   = 0;
        m_gap[i]   = 0;
      end
    end else begin
      mon_step(0, ifa.user_output, ifa.frame_done);
      mon_step(1, ifb.user_output, ifb.frame_done);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [11:0] d);
    if (i == 0) begin
      ifa.req_valid = v;
      ifa.req_data  = d;
    end else begin
      ifb.req_valid = v;
      ifb.req_data  = d;
    end
  endtask

  // Leaves req_valid high after acceptance so calls can run back to back.
  task automatic send(input int i, input logic [11:0] d);
    bit done;
    done = 1'b0;
    set_req(i, 1'b1, d);
    for (int t = 0; t < 3000 && !done; t++) begin
      if (rdy(i)) begin
        if (i == 0) exp0.push_back(d);
        else        exp1.push_back(d);
        last_acc[i] = cyc + 1;
        done = 1'b1;
      end
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout dut%0d: got ready 0, required acceptance of %h", i, d);
    end
  endtask

  task automatic drop(input int i);
    if (i == 0) ifa.req_valid = 1'b0;
    else        ifb.req_valid = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int target, input int limit);
    for (int t = 0; t < limit && fd_n[i] < target; t++) tick();
    checks++;
    if (fd_n[i] < target) begin
      errors++;
      $display("FAIL frame_timeout dut%0d: got %0d frame_done, required %0d", i, fd_n[i], target);
    end
  endtask

  task automatic wait_idle(input int i, input int limit);
    for (int t = 0; t < limit && bsy(i); t++) tick();
    checks++;
    if (bsy(i) !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout dut%0d: got busy %b, required 0", i, bsy(i));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks += 8;
    if (ifa.user_output !== 2'b00) begin errors++; $display("FAIL reset_sym_a: got %b, expected 00", ifa.user_output); end
    if (ifa.busy !== 1'b0)         begin errors++; $display("FAIL reset_busy_a: got %b, expected 0", ifa.busy); end
    if (ifa.frame_done !== 1'b0)   begin errors++; $display("FAIL reset_done_a: got %b, expected 0", ifa.frame_done); end
    if (ifa.req_ready !== 1'b1)    begin errors++; $display("FAIL reset_ready_a: got %b, expected 1", ifa.req_ready); end
    if (ifb.user_output !== 2'b00) begin errors++; $display("FAIL reset_sym_b: got %b, expected 00", ifb.user_output); end
    if (ifb.busy !== 1'b0)         begin errors++; $display("FAIL reset_busy_b: got %b, expected 0", ifb.busy); end
    if (ifb.frame_done !== 1'b0)   begin errors++; $display("FAIL reset_done_b: got %b, expected 0", ifb.frame_done); end
    if (ifb.req_ready !== 1'b1)    begin errors++; $display("FAIL reset_ready_b: got %b, expected 1", ifb.req_ready); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_frame();
    int s0, f0, fdc;
    s0 = start_n[0];
    f0 = fd_n[0];
    send(0, 12'hA5C);
    drop(0);
    wait_frames(0, f0 + 1, 1000);
    checks += 3;
    if (start_n[0] !== s0 + 1) begin errors++; $display("FAIL single_count: got %0d starts, expected %0d", start_n[0] - s0, 1); end
    if (start_log[0][s0] - last_acc[0] !== 2) begin
      errors++; $display("FAIL latency: got %0d, expected 2", start_log[0][s0] - last_acc[0]);
    end
    if (fd_log[0][f0] - start_log[0][s0] !== 425) begin
      errors++; $display("FAIL frame_len_a: got %0d, expected 425", fd_log[0][f0] - start_log[0][s0]);
    end
    fdc = fd_log[0][f0];
    while (cyc < fdc + 24) tick();
    checks++;
    if (ifa.busy !== 1'b1) begin errors++; $display("FAIL busy_in_gap: got %b, expected 1", ifa.busy); end
    tick();
    checks += 2;
    if (ifa.busy !== 1'b0) begin errors++; $display("FAIL busy_after_gap: got %b, expected 0", ifa.busy); end
    if (exp0.size() !== 0) begin errors++; $display("FAIL single_pending: got %0d, expected 0", exp0.size()); end
  endtask

  task automatic test_parity();
    int s0, f0;
    s0 = start_n[1];
    f0 = fd_n[1];
    send(1, 12'h007);
    drop(1);
    wait_frames(1, f0 + 1, 200);
    wait_idle(1, 50);
    checks += 2;
    if (fd_log[1][f0] - start_log[1][s0] !== 18) begin
      errors++; $display("FAIL parity_len: got %0d symbols, expected 18", fd_log[1][f0] - start_log[1][s0]);
    end
    if (start_log[1][s0] - last_acc[1] !== 2) begin
      errors++; $display("FAIL latency_b: got %0d, expected 2", start_log[1][s0] - last_acc[1]);
    end
  endtask

  task automatic test_back_to_back();
    int s0, f0;
    logic [11:0] vals [5];
    vals = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF};
    s0 = start_n[0];
    f0 = fd_n[0];
    for (int k = 0; k < 5; k++) send(0, vals[k]);
    checks++;
    if (ifa.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, expected 0", ifa.req_ready); end
    set_req(0, 1'b1, 12'hFFF);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (ifa.req_ready !== 1'b0) begin errors++; $display("FAIL blocked_ready: got %b, expected 0", ifa.req_ready); end
    end
    drop(0);
    wait_frames(0, f0 + 5, 3000);
    wait_idle(0, 100);
    repeat (5) tick();
    checks += 3;
    if (fd_n[0] - f0 !== 5) begin errors++; $display("FAIL b2b_done: got %0d, expected 5", fd_n[0] - f0); end
    if (start_n[0] - s0 !== 5) begin errors++; $display("FAIL b2b_frames: got %0d, expected 5", start_n[0] - s0); end
    if (exp0.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d, expected 0", exp0.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (start_log[0][s0+k+1] - start_log[0][s0+k] !== 451) begin
        errors++; $display("FAIL b2b_spacing%0d: got %0d, expected 451", k, start_log[0][s0+k+1] - start_log[0][s0+k]);
      end
    end
  endtask

  task automatic test_gap_zero();
    int s0, f0;
    s0 = start_n[1];
    f0 = fd_n[1];
    send(1, 12'h5A3);
    send(1, 12'h0F0);
    drop(1);
    wait_frames(1, f0 + 2, 200);
    wait_idle(1, 50);
    checks += 2;
    if (start_log[1][s0+1] - fd_log[1][f0] !== 1) begin
      errors++; $display("FAIL gap0_restart: got %0d, expected 1", start_log[1][s0+1] - fd_log[1][f0]);
    end
    if (start_log[1][s0+1] - start_log[1][s0] !== 19) begin
      errors++; $display("FAIL gap0_spacing: got %0d, expected 19", start_log[1][s0+1] - start_log[1][s0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s0, f0;
    s0 = start_n[0];
    f0 = fd_n[0];
    send(0, 12'h9E7);
    drop(0);
    for (int t = 0; t < 1000 && !(start_n[0] > s0 && m_pos[0] >= 153); t++) tick();
    checks++;
    if (!(start_n[0] > s0 && m_pos[0] >= 153)) begin
      errors++; $display("FAIL reach_symbol7: got pos %0d, required 153", m_pos[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (ifa.user_output !== 2'b00) begin errors++; $display("FAIL rst_mid_sym: got %b, expected 00", ifa.user_output); end
    if (ifa.busy !== 1'b0)         begin errors++; $display("FAIL rst_mid_busy: got %b, expected 0", ifa.busy); end
    if (ifa.frame_done !== 1'b0)   begin errors++; $display("FAIL rst_mid_done: got %b, expected 0", ifa.frame_done); end
    if (ifa.req_ready !== 1'b1)    begin errors++; $display("FAIL rst_mid_ready: got %b, expected 1", ifa.req_ready); end
    exp0.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks += 2;
    if (ifa.user_output !== 2'b00) begin errors++; $display("FAIL post_rst_sym: got %b, expected 00", ifa.user_output); end
    if (fd_n[0] !== f0) begin errors++; $display("FAIL aborted_done: got %0d, expected %0d", fd_n[0], f0); end
    send(0, 12'h3C1);
    drop(0);
    wait_frames(0, f0 + 1, 1000);
    wait_idle(0, 100);
    checks += 2;
    if (start_n[0] - s0 !== 2) begin errors++; $display("FAIL post_rst_frames: got %0d, expected 2", start_n[0] - s0); end
    if (fd_log[0][f0] - start_log[0][s0+1] !== 425) begin
      errors++; $display("FAIL post_rst_len: got %0d, expected 425", fd_log[0][f0] - start_log[0][s0+1]);
    end
  endtask

  task automatic test_random();
    int fa0, fb0;
    fa0 = fd_n[0];
    fb0 = fd_n[1];
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          send(0, 12'($urandom));
          if ($urandom_range(0, 1) == 1) begin
            drop(0);
            repeat ($urandom_range(1, 3)) tick();
          end
        end
        drop(0);
      end
      begin
        for (int k = 0; k < 15; k++) begin
          send(1, 12'($urandom));
          if ($urandom_range(0, 1) == 1) begin
            drop(1);
            repeat ($urandom_range(1, 30)) tick();
          end
        end
        drop(1);
      end
    join
    wait_frames(0, fa0 + 5, 4000);
    wait_frames(1, fb0 + 15, 2000);
    wait_idle(0, 100);
    wait_idle(1, 100);
    checks += 4;
    if (fd_n[0] - fa0 !== 5)  begin errors++; $display("FAIL rand_done_a: got %0d, expected 5", fd_n[0] - fa0); end
    if (fd_n[1] - fb0 !== 15) begin errors++; $display("FAIL rand_done_b: got %0d, expected 15", fd_n[1] - fb0); end
    if (exp0.size() !== 0)    begin errors++; $display("FAIL rand_pending_a: got %0d, expected 0", exp0.size()); end
    if (exp1.size() !== 0)    begin errors++; $display("FAIL rand_pending_b: got %0d, expected 0", exp1.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_n[i]  = 0;
      fd_n[i]     = 0;
      last_acc[i] = 0;
      m_bits[i]   = '0;
    end
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_gap_zero();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_serializer.md
REQUEST_SERIALIZER -- requirements
Module: request_serializer

Interface
REQ-001 Parameter DATA_W, default 12: request payload width, 1..32.
REQ-002 Parameter HDR, default 4'b1101, with HDR_W, default 4: frame header, sent MSB first.
REQ-003 Parameter PARITY_EN, default 0: 1 appends an even-parity bit over the payload.
REQ-004 Parameter BIT_CYCLES, default 25: clocks per symbol, at least 1.
REQ-005 Parameter GAP_CYCLES, default 25: idle clocks between frames, 0 allowed.
REQ-006 Parameter FIFO_DEPTH, default 4: request queue depth, a power of two, at least 2.
REQ-007 clk  in  1  system clock; all logic is rising-edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 req_data  in  DATA_W  request payload.
REQ-010 req_valid  in  1  req_data is valid this cycle.
REQ-011 req_ready  out  1  queue can accept; equals not-full.
REQ-012 user_output  out  2  line symbol: 01 = one, 10 = zero, 00 = idle.
REQ-013 busy  out  1  high while a frame or gap is in progress, or the queue is non-empty.
REQ-014 frame_done  out  1  one-cycle pulse after the last symbol of a frame.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; it is queued in FIFO order.
REQ-016 req_valid while req_ready is 0 SHALL be ignored and SHALL NOT corrupt the queue.
REQ-017 The frame SHALL be HDR, then req_data MSB first, then parity if PARITY_EN, then one stop bit 0; FRAME_W = HDR_W+DATA_W+PARITY_EN+1.
REQ-018 FSM states SHALL be IDLE, LOAD, SEND and GAP.
REQ-019 IDLE -> LOAD when the queue is non-empty. LOAD pops one entry into the shift register for one cycle, then -> SEND.
REQ-020 SEND SHALL drive each frame bit, registered, for exactly BIT_CYCLES clocks. After the stop bit: -> GAP if GAP_CYCLES>0, otherwise -> LOAD if the queue is non-empty, otherwise -> IDLE.
REQ-021 GAP SHALL drive 00 for exactly GAP_CYCLES clocks, then -> LOAD if the queue is non-empty, otherwise -> IDLE.
REQ-022 With an empty queue in IDLE, the first symbol SHALL appear on user_output 2 clocks after the accepting edge.
REQ-023 user_output SHALL be 00 in IDLE, LOAD and GAP.
REQ-024 Bit counter and cycle counter widths SHALL be clog2 of FRAME_W and clog2 of BIT_CYCLES, minimum 1; no wrap beyond their terminal values.
REQ-025 frame_done SHALL pulse in the first cycle after the stop bit's last clock, in parallel with the exit from SEND.
REQ-026 A push and a pop in the same cycle SHALL keep the occupancy unchanged. A push when full is impossible because req_ready is 0.
REQ-027 The output SHALL never show 11.

Reset
REQ-028 While rst_n is low: FSM in IDLE, queue emptied, counters 0, user_output 00, frame_done 0, busy 0, req_ready 1.
REQ-029 Reset asserted mid-frame SHALL force 00 immediately with no partial-frame completion. After release, operation SHALL restart from IDLE.

Structure
REQ-030 Package request_serializer_pkg SHALL hold the SYM_ONE, SYM_ZERO and SYM_IDLE constants and the FSM state typedef.
REQ-031 Sub-module request_fifo SHALL be parametrised by width and depth, with async active-low reset, push/pop/full/empty ports and registered occupancy.

Verification
REQ-032 Defaults, req_data 12'hA5C -> symbols for 1101_1010_0101_1100_0, each 25 clocks, then 25 clocks of 00, one frame_done pulse.
REQ-033 PARITY_EN=1, BIT_CYCLES=1, req_data 12'h007 -> parity bit 1 before the stop bit, 18 symbols total.
REQ-034 5 back-to-back requests with FIFO_DEPTH=4 -> req_ready low after 4 are held, all 5 frames sent in order, 5 frame_done pulses.
REQ-035 GAP_CYCLES=0, 2 requests queued -> second header starts the clock after LOAD, with no idle symbols other than LOAD's single 00.
REQ-036 rst_n pulled low at symbol 7 of a frame -> user_output 00 at once, busy 0; a new request after release -> full fresh frame.
REQ-037 Random traffic vs. a reference model -> symbol stream matches, 11 never seen, no lost or duplicated requests.
